// File: rtl/agc_pwr_seq_if.sv
// AGC power sequencer control/status bundle: lock/standby/power-cycle requests in,
// rail enables and sequencing status out.
interface agc_pwr_seq_if;
  logic       clk_locked;
  logic       sbyrel_n;
  logic       pwr_cyc;
  logic       p4vsw;
  logic       strt2;
  logic       sim_rst;
  logic       pwr_good;
  logic [2:0] state;

  modport master (
    output clk_locked, sbyrel_n, pwr_cyc,
    input  p4vsw, strt2, sim_rst, pwr_good, state
  );

  modport slave (
    input  clk_locked, sbyrel_n, pwr_cyc,
    output p4vsw, strt2, sim_rst, pwr_good, state
  );
endinterface

// File: rtl/agc_pwr_seq.sv
// AGC power-up / standby / power-cycle sequencer with registered Moore outputs.
// Standby path (SBY, REST) is built only when AGC_PWR_SBY_EN is defined.
module agc_pwr_seq #(
  parameter int unsigned STRT2_CYC = 409600,
  parameter int unsigned SBY_DLY   = 2048,
  parameter int unsigned RST_CYC   = 4096
) (
  input  logic         clk,
  input  logic         rst_n,
  agc_pwr_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StOff   = 3'd0,
    StWlock = 3'd1,
    StHold  = 3'd2,
    StRun   = 3'd3,
    StSby   = 3'd4,
    StRest  = 3'd5,
    StCyc   = 3'd6
  } state_e;

  // Terminal count for a duration; 0 behaves as 1, clamped to the 19-bit range.
  function automatic logic [18:0] last_of(int unsigned p);
    int unsigned e;
    e = (p == 32'd0) ? 32'd1 : p;
    if (e > 32'd524288) e = 32'd524288;
    return 19'(e - 32'd1);
  endfunction

  localparam logic [18:0] HoldLast = last_of(STRT2_CYC);
  localparam logic [18:0] RstLast  = last_of(RST_CYC);
`ifdef AGC_PWR_SBY_EN
  localparam logic [18:0] SbyLast  = last_of(SBY_DLY);
`else
  logic unused_sbyrel_n;
  assign unused_sbyrel_n = bus.sbyrel_n;
`endif

  state_e      state_q, state_d;
  logic [18:0] cnt_q, cnt_d, cnt_inc;
  logic        p4vsw_q, p4vsw_d;
  logic        strt2_q, strt2_d;
  logic        sim_rst_q, sim_rst_d;
  logic        pwr_good_q, pwr_good_d;

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 19'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StOff:   state_d = StWlock;
      StWlock: if (bus.clk_locked) state_d = StHold;
      StHold: begin
        if (!bus.clk_locked)      state_d = StWlock;
        else if (bus.pwr_cyc)     state_d = StCyc;
        else if (cnt_q >= HoldLast) state_d = StRun;
        else                      cnt_d = cnt_inc;
      end
      StRun: begin
        if (!bus.clk_locked)  state_d = StWlock;
        else if (bus.pwr_cyc) state_d = StCyc;
`ifdef AGC_PWR_SBY_EN
        else if (bus.sbyrel_n) cnt_d = '0;
        else if (cnt_q >= SbyLast) state_d = StSby;
        else                  cnt_d = cnt_inc;
`endif
      end
`ifdef AGC_PWR_SBY_EN
      StSby: begin
        if (!bus.clk_locked)  state_d = StWlock;
        else if (bus.pwr_cyc) state_d = StCyc;
        else if (!bus.sbyrel_n) cnt_d = '0;
        else if (cnt_q >= SbyLast) state_d = StRest;
        else                  cnt_d = cnt_inc;
      end
      StRest: begin
        if (!bus.clk_locked)  state_d = StWlock;
        else if (bus.pwr_cyc) state_d = StCyc;
        else if (cnt_q >= RstLast) state_d = StRun;
        else                  cnt_d = cnt_inc;
      end
`endif
      StCyc: begin
        // Lock loss and further pwr_cyc pulses are ignored while the rail is down.
        if (cnt_q >= RstLast) state_d = StWlock;
        else                  cnt_d = cnt_inc;
      end
      default: state_d = StOff;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs decoded from the next state so the registers track state_q exactly.
  always_comb begin
    p4vsw_d    = 1'b1;
    strt2_d    = 1'b1;
    sim_rst_d  = 1'b1;
    pwr_good_d = 1'b0;
    unique case (state_d)
      StOff, StWlock: ;
      StHold:  sim_rst_d = 1'b0;
      StRun: begin
        strt2_d    = 1'b0;
        sim_rst_d  = 1'b0;
        pwr_good_d = 1'b1;
      end
      StSby: begin
        p4vsw_d   = 1'b0;
        sim_rst_d = 1'b0;
      end
      StRest:  sim_rst_d = 1'b0;
      StCyc:   p4vsw_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StOff;
      cnt_q      <= '0;
      p4vsw_q    <= 1'b1;
      strt2_q    <= 1'b1;
      sim_rst_q  <= 1'b1;
      pwr_good_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p4vsw_q    <= p4vsw_d;
      strt2_q    <= strt2_d;
      sim_rst_q  <= sim_rst_d;
      pwr_good_q <= pwr_good_d;
    end
  end

  assign bus.p4vsw    = p4vsw_q;
  assign bus.strt2    = strt2_q;
  assign bus.sim_rst  = sim_rst_q;
  assign bus.pwr_good = pwr_good_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_agc_pwr_seq.sv
// Bench for agc_pwr_seq: directed sequences plus a random phase, all outputs compared
// every cycle against a time-in-state / streak-count reference model.
module tb_agc_pwr_seq;

  localparam int unsigned Strt2 = 16;
  localparam int unsigned Dly   = 4;
  localparam int unsigned Rst   = 8;
`ifdef AGC_PWR_SBY_EN
  localparam bit SbyEn = 1'b1;
`else
  localparam bit SbyEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: state number, cycles spent in it, current qualifying streak.
  int m_state = 0;
  int m_age = 0;
  int m_streak = 0;

  agc_pwr_seq_if bus ();

  agc_pwr_seq #(
    .STRT2_CYC (Strt2),
    .SBY_DLY   (Dly),
    .RST_CYC   (Rst)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {p4vsw, strt2, sim_rst, pwr_good} for each state number
  function automatic logic [3:0] exp_out(int s);
    case (s)
      2:       return 4'b1100;
      3:       return 4'b1001;
      4:       return 4'b0100;
      5:       return 4'b1100;
      6:       return 4'b0110;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [3:0] e;
    e = exp_out(m_state);
    check({tag, ".state"}, 32'(bus.state), 32'(m_state));
    check({tag, ".p4vsw"}, 32'(bus.p4vsw), 32'(e[3]));
    check({tag, ".strt2"}, 32'(bus.strt2), 32'(e[2]));
    check({tag, ".sim_rst"}, 32'(bus.sim_rst), 32'(e[1]));
    check({tag, ".pwr_good"}, 32'(bus.pwr_good), 32'(e[0]));
  endtask

  task automatic model_step(input bit lk, input bit sb, input bit pc);
    int nxt;
    bool_streak: begin end
    nxt = m_state;
    if (m_state == 0) nxt = 1;
    else if (m_state == 1) begin
      if (lk) nxt = 2;
    end else if (m_state == 6) begin
      if (m_age + 1 >= int'(Rst)) nxt = 1;
    end else begin
      if (!lk) nxt = 1;
      else if (pc) nxt = 6;
      else if (m_state == 2 && m_age + 1 >= int'(Strt2)) nxt = 3;
      else if (m_state == 3 && SbyEn && !sb && m_streak + 1 >= int'(Dly)) nxt = 4;
      else if (m_state == 4 && sb && m_streak + 1 >= int'(Dly)) nxt = 5;
      else if (m_state == 5 && m_age + 1 >= int'(Rst)) nxt = 3;
    end
    if (nxt != m_state) begin
      m_state = nxt;
      m_age = 0;
      m_streak = 0;
    end else begin
      m_age++;
      if (m_state == 3) m_streak = sb ? 0 : m_streak + 1;
      else              m_streak = sb ? m_streak + 1 : 0;
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_age = 0;
    m_streak = 0;
  endtask

  task automatic tick(input bit lk, input bit sb, input bit pc, input string tag);
    bus.clk_locked = lk;
    bus.sbyrel_n   = sb;
    bus.pwr_cyc    = pc;
    @(posedge clk);
    model_step(lk, sb, pc);
    #1;
    check_all(tag);
  endtask

  initial begin
    int n;
    int glen;
    bit sb_lvl;
    bit lk;
    bit pc;

    bus.clk_locked = 1'b1;
    bus.sbyrel_n   = 1'b1;
    bus.pwr_cyc    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    #4 rst_n = 1'b1;

    // Power-up: one WLOCK cycle, STRT2 held for exactly Strt2 cycles.
    tick(1, 1, 0, "wlock");
    check("wlock_state", 32'(bus.state), 32'd1);
    n = 0;
    do begin
      tick(1, 1, 0, "hold");
      if (bus.state == 3'd2) n++;
    end while (bus.state == 3'd2 && n < 40);
    check("hold_cycles", n, Strt2);
    check("run_strt2", 32'(bus.strt2), 32'd0);
    check("run_pwr_good", 32'(bus.pwr_good), 32'd1);

`ifdef AGC_PWR_SBY_EN
    // Low glitches shorter than the filter must not reach SBY.
    for (int g = 0; g < 4; g++) begin
      glen = (g == 0) ? 3 : int'($urandom_range(1, Dly - 1));
      repeat (glen) tick(1, 0, 0, "glitch_lo");
      tick(1, 1, 0, "glitch_hi");
    end
    check("glitch_stays_run", 32'(bus.state), 32'd3);
    repeat (Dly) tick(1, 0, 0, "sby_req");
    check("sby_state", 32'(bus.state), 32'd4);
    check("sby_p4vsw", 32'(bus.p4vsw), 32'd0);
    repeat (2) tick(1, 1, 0, "sby_glitch_hi");
    tick(1, 0, 0, "sby_glitch_lo");
    check("sby_glitch_stays", 32'(bus.state), 32'd4);
    repeat (Dly) tick(1, 1, 0, "sby_exit");
    check("rest_state", 32'(bus.state), 32'd5);
    repeat (Rst - 1) tick(1, 1, 0, "rest");
    check("rest_held", 32'(bus.state), 32'd5);
    tick(1, 1, 0, "rest_done");
    check("rest_to_run", 32'(bus.state), 32'd3);
`else
    repeat (100) tick(1, 0, 0, "sby_ignored");
    check("nosby_state", 32'(bus.state), 32'd3);
    check("nosby_p4vsw", 32'(bus.p4vsw), 32'd1);
`endif

    // Power cycle from RUN.
    tick(1, 1, 1, "pwr_cyc");
    check("cyc_state", 32'(bus.state), 32'd6);
    check("cyc_sim_rst", 32'(bus.sim_rst), 32'd1);
    n = 1;
    while (n < 40) begin
      tick(1, 1, (n == 3), "cyc");
      if (bus.state != 3'd6) break;
      n++;
    end
    check("cyc_cycles", n, Rst);
    check("cyc_to_wlock", 32'(bus.state), 32'd1);
    tick(1, 1, 0, "rehold");
    repeat (Strt2) tick(1, 1, 0, "rehold_run");
    check("cyc_back_to_run", 32'(bus.state), 32'd3);

    // Lock loss beats pwr_cyc in HOLD; async reset mid-HOLD.
    tick(1, 1, 1, "cyc2");
    repeat (Rst) tick(1, 1, 0, "cyc2_wait");
    tick(1, 1, 0, "hold2");
    repeat (3) tick(1, 1, 0, "hold2_cnt");
    tick(0, 1, 1, "lock_vs_cyc");
    check("lock_priority", 32'(bus.state), 32'd1);
    tick(1, 1, 0, "hold3");
    repeat (5) tick(1, 1, 0, "hold3_cnt");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_state", 32'(bus.state), 32'd0);
    check_all("async_rst");
    #3 rst_n = 1'b1;

    // Random phase against the model.
    sb_lvl = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      lk = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 5) == 0) sb_lvl = ~sb_lvl;
      pc = ($urandom_range(0, 79) == 0);
      tick(lk, sb_lvl, pc, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
